fixed_point_adder: RTL and testbench
====================================

# fixed_point_adder

Saturating adder for sign-magnitude fixed-point fractions. It sums two operands and registers the result with a one-cycle latency and a valid strobe. On overflow it clamps to full-scale and raises an overflow flag. It is used as the accumulation and add primitive in the fixed-point datapath, between the multiplier stages and the activation logic.

## Interface
- `BITSIZE`, default 20: total word width. It must be at least 2: 1 sign bit plus `BITSIZE-1` fraction bits.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `A` and `B` are valid this cycle.
- `A` input `BITSIZE`: operand A, sign-magnitude.
- `B` input `BITSIZE`: operand B, sign-magnitude.
- `out_valid` output 1: `C` holds a new result this cycle.
- `C` output `BITSIZE`: registered sum, sign-magnitude.
- `ovf` output 1: overflow/saturation indicator (see Configuration).

## Operation
- **Number format:**
  - Bit `[BITSIZE-1]` is the sign; 1 means negative.
  - Bits `[BITSIZE-2:0]` are the unsigned magnitude.
  - Value = (−1)^s · mag / 2^(BITSIZE−1). Representable range is ±(1 − 2^−(BITSIZE−1)).
- **Negative zero on input:** a magnitude-0 input is treated as +0, whatever its sign bit.
- **Same signs:**
  - Add the magnitudes with one extra carry bit.
  - If the carry is set, saturate the magnitude to all ones, keep the common sign, and set overflow.
  - Otherwise the result is the sum, with the common sign.
- **Different signs:**
  - The result magnitude is the larger magnitude minus the smaller one.
  - The result sign is the sign of the larger magnitude.
  - Equal magnitudes give +0. Overflow cannot occur.
- **Output zero:** the block never emits negative zero. A zero result is always all-zeros.
- **Arithmetic width:** internal magnitude arithmetic is `BITSIZE` bits wide: the magnitude plus a carry. No rounding. The fraction is exact because the operand scales are identical.
- **`in_valid` high:** `C` is updated and the overflow status is evaluated.
- **`in_valid` low:** `C` holds its previous value and `out_valid` is 0.

## Timing
- Latency is 1 cycle. The result for operands sampled at edge n appears on `C` after edge n.
- `out_valid` is high for exactly the cycle after each accepted `in_valid`.
- Full throughput: back-to-back `in_valid` produces a result every cycle.
- Reset values: `C` = 0, `out_valid` = 0, `ovf` = 0.
- `rst` has priority over `in_valid` in the same cycle; the operands are discarded.
- Reset asserted mid-stream discards the pending result. The first valid input after `rst` deasserts produces output one cycle later.
- There is no back-pressure; the downstream consumer must accept every result.

## Configuration
- Macro: `FIXED_POINT_ADD_STICKY_OVF_EN`.
- **Defined:** `ovf` is sticky.
  - It sets on any accepted operation that saturates.
  - It stays high until `rst`.
- **Not defined:** `ovf` is per-result.
  - It updates with each accepted operation to that operation's saturation status.
  - It holds its value when `in_valid` is low.

## Test plan
- **Reset and sum:**
  - Hold `rst` high: `C`=0, `out_valid`=0, `ovf`=0.
  - Release `rst`, then apply `A`=0x10000, `B`=0x10000 with `in_valid` → next cycle `C`=0x20000, `out_valid`=1, `ovf`=0.
- **Positive saturation:**
  - 0x7FFFF + 0x00001 → `C`=0x7FFFF, `ovf`=1.
  - 0x7FFFF + 0x10000 → 0x7FFFF.
  - 0x20000 + 0x60000 (0.25 + 0.75) → 0x7FFFF, `ovf`=1.
- **Mixed signs:**
  - 0x40000 + 0xC0000 → 0x00000.
  - 0xA0000 (−0.25) + 0x40000 (0.5) → 0x20000.
  - 0xC0000 (−0.5) + 0x20000 (0.25) → 0xA0000.
  - `ovf` stays 0 in this scenario.
- **Negative saturation:**
  - 0xC0000 + 0xC0000 → 0xFFFFF, `ovf`=1.
  - 0x80000 (−0) + 0x00000 → 0x00000.
- **Valid and reset handling:**
  - Deassert `in_valid` → `C` holds, `out_valid`=0.
  - Assert `rst` and `in_valid` together → `C`=0, `out_valid`=0 the next cycle.
  - Back-to-back inputs → one result per cycle.
- **Overflow mode:**
  - A saturating operation followed by a normal one gives `ovf` = 1, 1 with `FIXED_POINT_ADD_STICKY_OVF_EN` defined.
  - The same sequence gives `ovf` = 1, 0 with the macro not defined.

Source files
------------

// File: rtl/fixed_point_adder.sv
// rtl/fixed_point_adder.sv - saturating sign-magnitude fixed-point adder, 1-cycle latency
// Define FIXED_POINT_ADD_STICKY_OVF_EN to make ovf sticky until rst.
module fixed_point_adder #(
  parameter int BITSIZE = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  output logic               out_valid,
  output logic [BITSIZE-1:0] C,
  output logic               ovf
);

  localparam int M = BITSIZE - 1;

  logic [M-1:0]       a_mag, b_mag, res_mag;
  logic               a_sgn, b_sgn, res_sgn;
  logic [BITSIZE-1:0] mag_sum;
  logic               sat;

  logic [BITSIZE-1:0] c_d, c_q;
  logic               out_valid_d, out_valid_q;
  logic               ovf_d, ovf_q;

  always_comb begin
    a_mag   = A[M-1:0];
    b_mag   = B[M-1:0];
    // A zero magnitude is +0 regardless of its sign bit.
    a_sgn   = A[M] & (|a_mag);
    b_sgn   = B[M] & (|b_mag);
    mag_sum = {1'b0, a_mag} + {1'b0, b_mag};
    sat     = 1'b0;
    res_mag = '0;
    res_sgn = 1'b0;
    if (a_sgn == b_sgn) begin
      res_sgn = a_sgn;
      if (mag_sum[M]) begin
        res_mag = '1;
        sat     = 1'b1;
      end else begin
        res_mag = mag_sum[M-1:0];
      end
    end else if (a_mag >= b_mag) begin
      res_mag = a_mag - b_mag;
      res_sgn = a_sgn;
    end else begin
      res_mag = b_mag - a_mag;
      res_sgn = b_sgn;
    end
  end

  always_comb begin
    c_d         = c_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d = {res_sgn & (|res_mag), res_mag};
    end
`ifdef FIXED_POINT_ADD_STICKY_OVF_EN
    ovf_d = ovf_q | (in_valid & sat);
`else
    ovf_d = in_valid ? sat : ovf_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign C         = c_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_point_adder.sv
// tb/tb_fixed_point_adder.sv - self-checking bench for fixed_point_adder against an integer-value model
module tb_fixed_point_adder;

  localparam int W   = 20;
  localparam int M   = W - 1;
  localparam int MAX = (1 << M) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic [W-1:0] C;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_c   = '0;
  logic         exp_v   = 1'b0;
  logic         exp_ovf = 1'b0;

  fixed_point_adder #(.BITSIZE(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid), .C(C), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: decode to signed integers, add, clamp, re-encode.
  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            output logic sat);
    int va, vb, s;
    logic [M-1:0] m;
    va  = a[M] ? -int'(a[M-1:0]) : int'(a[M-1:0]);
    vb  = b[M] ? -int'(b[M-1:0]) : int'(b[M-1:0]);
    s   = va + vb;
    sat = 1'b0;
    if (s > MAX)  begin s = MAX;  sat = 1'b1; end
    if (s < -MAX) begin s = -MAX; sat = 1'b1; end
    if (s < 0) begin
      m = M'(-s);
      return {1'b1, m};
    end
    m = M'(s);
    return {1'b0, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    logic s;
    logic [W-1:0] res;
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b;
    @(posedge clk);
    #1;
    res = ref_add(a, b, s);
    if (r) begin
      exp_c = '0; exp_v = 1'b0; exp_ovf = 1'b0;
    end else if (v) begin
      exp_c = res; exp_v = 1'b1;
`ifdef FIXED_POINT_ADD_STICKY_OVF_EN
      exp_ovf = exp_ovf | s;
`else
      exp_ovf = s;
`endif
    end else begin
      exp_v = 1'b0;
    end
    chk({tag, ".C"}, 32'(C), 32'(exp_c));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic add_exp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c_lit);
    step(tag, 1'b0, 1'b1, a, b);
    chk({tag, ".lit"}, 32'(C), 32'(c_lit));
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] x;
    x = W'($urandom);
    case ($urandom_range(0, 5))
      0: x[M-1:0] = '1;
      1: x[M-1:0] = '0;
      2: x[M-1:0] = M'($urandom_range(0, 3));
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    step("reset0", 1'b1, 1'b0, '0, '0);
    step("reset1", 1'b1, 1'b1, 20'h7FFFF, 20'h7FFFF);
    chk("reset.C_lit", 32'(C), 32'h0);
    chk("reset.ovf_lit", 32'(ovf), 32'h0);

    add_exp("sum", 20'h10000, 20'h10000, 20'h20000);
    chk("sum.ovf_lit", 32'(ovf), 32'h0);

    add_exp("psat1", 20'h7FFFF, 20'h00001, 20'h7FFFF);
    chk("psat1.ovf_lit", 32'(ovf), 32'h1);
    add_exp("psat2", 20'h7FFFF, 20'h10000, 20'h7FFFF);
    add_exp("psat3", 20'h20000, 20'h60000, 20'h7FFFF);

    step("clr", 1'b1, 1'b0, '0, '0);
    add_exp("mix1", 20'h40000, 20'hC0000, 20'h00000);
    add_exp("mix2", 20'hA0000, 20'h40000, 20'h20000);
    add_exp("mix3", 20'hC0000, 20'h20000, 20'hA0000);
    chk("mix.ovf_lit", 32'(ovf), 32'h0);
    add_exp("mix_max", 20'hFFFFF, 20'h7FFFF, 20'h00000);

    add_exp("nsat", 20'hC0000, 20'hC0000, 20'hFFFFF);
    chk("nsat.ovf_lit", 32'(ovf), 32'h1);
    add_exp("negzero", 20'h80000, 20'h00000, 20'h00000);
    add_exp("negzero2", 20'h80000, 20'h80005, 20'h80005);
    add_exp("edge_max", 20'h7FFFE, 20'h00001, 20'h7FFFF);

    step("hold", 1'b0, 1'b0, 20'h12345, 20'h54321);
    step("hold2", 1'b0, 1'b0, 20'h7FFFF, 20'h7FFFF);
    step("rst_and_valid", 1'b1, 1'b1, 20'h12345, 20'h01111);
    chk("rst_and_valid.C_lit", 32'(C), 32'h0);
    add_exp("after_rst", 20'h00003, 20'h00004, 20'h00007);

    add_exp("ovf_mode_sat", 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    chk("ovf_mode_sat.lit", 32'(ovf), 32'h1);
    add_exp("ovf_mode_norm", 20'h00001, 20'h00001, 20'h00002);
`ifdef FIXED_POINT_ADD_STICKY_OVF_EN
    chk("ovf_mode_norm.lit", 32'(ovf), 32'h1);
`else
    chk("ovf_mode_norm.lit", 32'(ovf), 32'h0);
`endif

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           rand_op(), rand_op());
    end
    for (int i = 0; i < 20; i++) begin
      step("b2b", 1'b0, 1'b1, rand_op(), rand_op());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
